// File: rtl/half_adder_pkg.sv
// Shared constants and types for the half_adder slice.
// Default lane count and counter width; override via half_adder parameters.
package half_adder_pkg;

    localparam int unsigned HA_WIDTH     = 1;
    localparam int unsigned HA_CNT_W     = 16;
    localparam int unsigned HA_MAX_WIDTH = 64;
    localparam int unsigned HA_MAX_CNT_W = 32;

    typedef logic [HA_WIDTH-1:0] lane_vec_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_bit.sv
// Single-lane combinational half adder.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule : half_adder_bit

// File: rtl/half_adder.sv
// WIDTH-lane half adder with a combinational path, a one-cycle registered path,
// and an optional saturating carry counter enabled by HALF_ADDER_STATS_EN.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH,
    parameter int unsigned CNT_W = HA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    // Independent lanes: no carry chain between them.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        half_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum[i]),
            .carry (carry[i])
        );
    end

    // Registered result; holds its value while no operand is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_valid && (|carry) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign carry_count = cnt_q;
`else
    assign carry_count = '0;
`endif

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: directed vectors, queue-based result checking.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic [3:0] sum, carry, sum_q, carry_q;
    logic       out_valid;
    logic [1:0] carry_count;

    logic       a1, b1;
    logic       sum1, carry1, sum_q1, carry_q1, out_valid1;
    logic [15:0] carry_count1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] c;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    half_adder #(.WIDTH(4), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .sum         (sum),
        .carry       (carry),
        .in_valid    (in_valid),
        .sum_q       (sum_q),
        .carry_q     (carry_q),
        .out_valid   (out_valid),
        .carry_count (carry_count)
    );

    half_adder dut1 (
        .clk         (clk),
        .rst         (rst),
        .a           (a1),
        .b           (b1),
        .sum         (sum1),
        .carry       (carry1),
        .in_valid    (1'b0),
        .sum_q       (sum_q1),
        .carry_q     (carry_q1),
        .out_valid   (out_valid1),
        .carry_count (carry_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum_q", 32'(sum_q), 32'(e.s));
                    chk("carry_q", 32'(carry_q), 32'(e.c));
                end
            end
        end
    end

    // One clock edge with hand-computed combinational and counter expectations.
    task automatic cycle(input logic r, input logic iv, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] es, input logic [3:0] ec, input int ecnt);
        rst      = r;
        in_valid = iv;
        a        = av;
        b        = bv;
        #1;
        chk("sum", 32'(sum), 32'(es));
        chk("carry", 32'(carry), 32'(ec));
        if (iv && !r) exp_q.push_back('{s: es, c: ec});
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(iv && !r));
`ifdef HALF_ADDER_STATS_EN
        chk("carry_count", 32'(carry_count), 32'(ecnt));
`else
        chk("carry_count", 32'(carry_count), 32'd0);
`endif
    endtask

    initial begin
        logic [1:0] va [6];
        logic [1:0] vr [6];
        int         cnt_seq [5];
        va = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        vr = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
        cnt_seq = '{1, 2, 3, 3, 3};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; a1 = 1'b0; b1 = 1'b0;

        // Single-lane combinational vectors, 50 time units apart.
        for (int i = 0; i < 6; i++) begin
            a1 = va[i][1];
            b1 = va[i][0];
            #1;
            chk("w1_sum", 32'(sum1), 32'(vr[i][1]));
            chk("w1_carry", 32'(carry1), 32'(vr[i][0]));
            #49;
        end

        @(negedge clk);
        cycle(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        chk("rst_sum_q", 32'(sum_q), 32'd0);
        chk("rst_carry_q", 32'(carry_q), 32'd0);

        cycle(1'b0, 1'b1, 4'b1100, 4'b1010, 4'b0110, 4'b1000, 1);
        cycle(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2);
        cycle(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
        chk("hold_sum_q", 32'(sum_q), 32'h0);
        chk("hold_carry_q", 32'(carry_q), 32'h1);
        cycle(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2);
        chk("hold2_carry_q", 32'(carry_q), 32'h1);

        // Accepted op without any carry leaves the counter alone.
        cycle(1'b0, 1'b1, 4'b0101, 4'b0010, 4'b0111, 4'b0000, 2);
        cycle(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 3);
        cycle(1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 3);
        cycle(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 3);

        // Reset with a capture pending discards it; comb outputs unaffected.
        cycle(1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0);
        chk("rstmid_sum_q", 32'(sum_q), 32'd0);
        chk("rstmid_carry_q", 32'(carry_q), 32'd0);
        chk("rstmid_sum", 32'(sum), 32'h0);
        chk("rstmid_carry", 32'(carry), 32'h1);

        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, cnt_seq[i]);

        cycle(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_half_adder
